// File: rtl/window_realign_reader.sv
// Read side of the window line buffer: fetches every block of one row with
// fixed-latency reads, undoes the writer's OFFSET-word shift by stitching each
// block with the tail of its predecessor, and streams the result through a
// credit-protected first-word-fall-through FIFO.
module window_realign_reader #(
  parameter int WORDS        = 8,
  parameter int WORD_SIZE    = 8,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET       = 0,
  parameter int NUM_BLOCKS   = 4,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [INDEX_WIDTH-1:0]       startY,
  output logic                         busy,
  output logic                         done,
  output logic                         re,
  output logic [INDEX_WIDTH-1:0]       raddrY,
  output logic [INDEX_WIDTH-1:0]       raddrBlock,
  input  logic [WORDS*WORD_SIZE-1:0]   rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORDS*WORD_SIZE-1:0]   out_data,
  output logic [INDEX_WIDTH-1:0]       out_block,
  output logic                         out_last
);

  localparam int DATA_W = WORDS * WORD_SIZE;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SLOTS  = 1 << PTR_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int SHIFT  = (WORDS - OFFSET) * WORD_SIZE;

  localparam logic [INDEX_WIDTH:0]   LAST_ISSUE   = (INDEX_WIDTH + 1)'(NUM_BLOCKS - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_BLOCK   = INDEX_WIDTH'(NUM_BLOCKS - 1);
  localparam logic [PTR_W-1:0]       PTR_MAX      = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]         CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } stateType;

  stateType               state;
  stateType               stateNext;
  logic                   accept;
  logic                   issue;
  logic                   finish;
  logic                   creditOk;
  logic [INDEX_WIDTH:0]   rdIdx;
  logic [DATA_W-1:0]      prevBlock;
  logic [DATA_W-1:0]      realigned;

  logic [READ_LATENCY-1:0] validPipe;
  logic [INDEX_WIDTH-1:0]  idxPipe [READ_LATENCY];
  logic [CNT_W-1:0]        inflight;
  logic                    ret;
  logic [INDEX_WIDTH-1:0]  retBlock;

  logic [DATA_W-1:0]       fifoData  [SLOTS];
  logic [INDEX_WIDTH-1:0]  fifoBlock [SLOTS];
  logic                    fifoLast  [SLOTS];
  logic [PTR_W-1:0]        wrPtr;
  logic [PTR_W-1:0]        rdPtr;
  logic [CNT_W-1:0]        fifoCount;
  logic                    pop;

  // A read is only allowed when every outstanding return already has a FIFO slot
  // reserved, so back-pressure can never force a returned block to be dropped.
  assign creditOk = ({1'b0, inflight} + {1'b0, fifoCount}) < CREDIT_LIMIT;

  assign ret      = validPipe[READ_LATENCY-1];
  assign retBlock = idxPipe[READ_LATENCY-1];

  // Word x of the realigned block is word x+WORDS-OFFSET of {current, previous};
  // with OFFSET=0 this is exactly the current block.
  assign realigned = DATA_W'({rdata, prevBlock} >> SHIFT);

  assign out_valid = (fifoCount != '0);
  assign out_data  = fifoData[rdPtr];
  assign out_block = fifoBlock[rdPtr];
  assign out_last  = fifoLast[rdPtr];
  assign pop       = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state and per-cycle control decisions: accept a row, issue a read, finish the row.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          stateNext = READ;
        end
      end
      READ: begin
        if (creditOk) begin
          issue = 1'b1;
          if (rdIdx == LAST_ISSUE) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Registered read port, row latch, issue counter, status flags and stitch history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re         <= 1'b0;
      raddrY     <= '0;
      raddrBlock <= '0;
      rdIdx      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      prevBlock  <= '0;
    end else begin
      re   <= issue;
      done <= finish;
      if (accept) begin
        raddrY <= startY;
        rdIdx  <= '0;
        busy   <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end
      if (issue) begin
        raddrBlock <= rdIdx[INDEX_WIDTH-1:0];
        rdIdx      <= rdIdx + 1'b1;
      end
      if (accept)   prevBlock <= '0;
      else if (ret) prevBlock <= rdata;
    end
  end

  // Latency pipe marking the cycle each read returns, plus the outstanding-read counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validPipe <= '0;
      for (int k = 0; k < READ_LATENCY; k++) idxPipe[k] <= '0;
      inflight <= '0;
    end else begin
      validPipe[0] <= re;
      idxPipe[0]   <= raddrBlock;
      for (int k = 1; k < READ_LATENCY; k++) begin
        validPipe[k] <= validPipe[k-1];
        idxPipe[k]   <= idxPipe[k-1];
      end
      if (issue && !ret)      inflight <= inflight + 1'b1;
      else if (!issue && ret) inflight <= inflight - 1'b1;
    end
  end

  // Realigned-block FIFO; pushes on every return, pops on the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SLOTS; s++) begin
        fifoData[s]  <= '0;
        fifoBlock[s] <= '0;
        fifoLast[s]  <= 1'b0;
      end
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (ret) begin
        fifoData[wrPtr]  <= realigned;
        fifoBlock[wrPtr] <= retBlock;
        fifoLast[wrPtr]  <= (retBlock == LAST_BLOCK);
        wrPtr            <= (wrPtr == PTR_MAX) ? '0 : wrPtr + 1'b1;
      end
      if (pop) rdPtr <= (rdPtr == PTR_MAX) ? '0 : rdPtr + 1'b1;
      if (ret && !pop)      fifoCount <= fifoCount + 1'b1;
      else if (!ret && pop) fifoCount <= fifoCount - 1'b1;
    end
  end

endmodule

// File: tb/tb_window_realign_reader.sv
// Directed bench for window_realign_reader: three instances share one clock --
// [0] OFFSET=1/FIFO_DEPTH=4, [1] OFFSET=1/FIFO_DEPTH=1, [2] OFFSET=0/FIFO_DEPTH=4 --
// each fed by a two-cycle memory whose word w of block b is 8'h{b,w}.
module tb_window_realign_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start      [3];
  logic [7:0]  startY     [3];
  logic        busy       [3];
  logic        done       [3];
  logic        re         [3];
  logic [7:0]  raddrY     [3];
  logic [7:0]  raddrBlock [3];
  logic [31:0] rdata      [3];
  logic        out_valid  [3];
  logic        out_ready  [3];
  logic [31:0] out_data   [3];
  logic [7:0]  out_block  [3];
  logic        out_last   [3];

  int compared   = 0;
  int mismatched = 0;

  int          cyc;
  int          reCnt;
  int          beatCnt;
  int          doneCnt;
  int          doneCyc;
  int          hsCyc;
  int          unstable;
  int          reCyc    [8];
  logic [7:0]  reBlk    [8];
  logic [7:0]  reY      [8];
  logic [31:0] beatData [8];
  logic [7:0]  beatBlk  [8];
  logic        beatLast [8];

  function automatic logic [31:0] blockWord(input logic [7:0] b);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = {b[3:0], 4'(k)};
    return w;
  endfunction

  // Free-running clock.
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gInst
    logic [7:0] stage1;

    window_realign_reader #(
      .WORDS(4), .WORD_SIZE(8), .INDEX_WIDTH(8),
      .OFFSET((g == 2) ? 0 : 1), .NUM_BLOCKS(3), .READ_LATENCY(2),
      .FIFO_DEPTH((g == 1) ? 1 : 4)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .startY(startY[g]),
      .busy(busy[g]), .done(done[g]), .re(re[g]), .raddrY(raddrY[g]),
      .raddrBlock(raddrBlock[g]), .rdata(rdata[g]), .out_valid(out_valid[g]),
      .out_ready(out_ready[g]), .out_data(out_data[g]), .out_block(out_block[g]),
      .out_last(out_last[g])
    );

    // Two-cycle memory: address captured behind re, data presented one edge later.
    always @(posedge clk) begin
      stage1   <= raddrBlock[g];
      rdata[g] <= blockWord(stage1);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    reCnt = 0; beatCnt = 0; doneCnt = 0; doneCyc = -1; hsCyc = -1; unstable = 0;
    for (int i = 0; i < 8; i++) begin
      reCyc[i] = -1; reBlk[i] = '0; reY[i] = '0;
      beatData[i] = '0; beatBlk[i] = '0; beatLast[i] = 1'b0;
    end
  endtask

  // One cycle: log the handshake the coming edge will perform, then log re/done after it.
  task automatic sample(input int g);
    if (out_valid[g] && out_ready[g]) begin
      if (beatCnt < 8) begin
        beatData[beatCnt] = out_data[g];
        beatBlk[beatCnt]  = out_block[g];
        beatLast[beatCnt] = out_last[g];
      end
      beatCnt++;
      hsCyc = cyc;
    end
    @(negedge clk);
    cyc++;
    if (re[g]) begin
      if (reCnt < 8) begin
        reCyc[reCnt] = cyc;
        reBlk[reCnt] = raddrBlock[g];
        reY[reCnt]   = raddrY[g];
      end
      reCnt++;
    end
    if (done[g]) begin
      doneCnt++;
      doneCyc = cyc;
    end
  endtask

  task automatic runCycles(input int g, input int n);
    for (int i = 0; i < n; i++) sample(g);
  endtask

  task automatic runUntilDone(input int g, input string tag);
    int i;
    i = 0;
    while (doneCnt == 0 && i < 60) begin
      sample(g);
      i++;
    end
    checkOutput({tag, " done seen"}, 64'(doneCnt != 0), 64'd1);
  endtask

  // One-cycle start pulse on instance g.
  task automatic applyStimulus(input int g, input logic [7:0] y);
    start[g]  = 1'b1;
    startY[g] = y;
    sample(g);
    start[g]  = 1'b0;
  endtask

  task automatic checkRow(input string tag, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    checkOutput({tag, " beats"},  64'(beatCnt), 64'd3);
    checkOutput({tag, " data0"},  64'(beatData[0]), 64'(e0));
    checkOutput({tag, " data1"},  64'(beatData[1]), 64'(e1));
    checkOutput({tag, " data2"},  64'(beatData[2]), 64'(e2));
    checkOutput({tag, " block0"}, 64'(beatBlk[0]), 64'd0);
    checkOutput({tag, " block1"}, 64'(beatBlk[1]), 64'd1);
    checkOutput({tag, " block2"}, 64'(beatBlk[2]), 64'd2);
    checkOutput({tag, " last0"},  64'(beatLast[0]), 64'd0);
    checkOutput({tag, " last1"},  64'(beatLast[1]), 64'd0);
    checkOutput({tag, " last2"},  64'(beatLast[2]), 64'd1);
  endtask

  // Overall time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    cyc   = 0;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0; startY[g] = '0; out_ready[g] = 1'b0;
    end
    clearLog();
    runCycles(0, 2);

    $display("[TB] reset state");
    checkOutput("reset re",        64'(re[0]), 64'd0);
    checkOutput("reset busy",      64'(busy[0]), 64'd0);
    checkOutput("reset done",      64'(done[0]), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid[0]), 64'd0);
    checkOutput("reset out_data",  64'(out_data[0]), 64'd0);
    checkOutput("reset raddrY",    64'(raddrY[0]), 64'd0);
    rst_n = 1'b1;
    runCycles(0, 2);

    $display("[TB] basic row");
    clearLog();
    out_ready[0] = 1'b1;
    applyStimulus(0, 8'd5);
    checkOutput("basic busy", 64'(busy[0]), 64'd1);
    runUntilDone(0, "basic");
    runCycles(0, 5);
    checkOutput("basic re count",  64'(reCnt), 64'd3);
    checkOutput("basic re span",   64'(reCyc[2] - reCyc[0]), 64'd2);
    checkOutput("basic raddrY0",   64'(reY[0]), 64'd5);
    checkOutput("basic raddrY2",   64'(reY[2]), 64'd5);
    checkOutput("basic raddrBlk0", 64'(reBlk[0]), 64'd0);
    checkOutput("basic raddrBlk1", 64'(reBlk[1]), 64'd1);
    checkOutput("basic raddrBlk2", 64'(reBlk[2]), 64'd2);
    checkRow("basic", 32'h0201_0000, 32'h1211_1003, 32'h2221_2013);
    checkOutput("basic done timing", 64'(doneCyc - hsCyc), 64'd1);
    checkOutput("basic done count",  64'(doneCnt), 64'd1);
    checkOutput("basic busy after",  64'(busy[0]), 64'd0);

    $display("[TB] back-pressure");
    clearLog();
    out_ready[0] = 1'b0;
    applyStimulus(0, 8'd5);
    for (int i = 0; i < 20; i++) begin
      sample(0);
      if (out_valid[0] && out_data[0] !== 32'h0201_0000) unstable++;
    end
    checkOutput("bp re count",  64'(reCnt), 64'd3);
    checkOutput("bp out_valid", 64'(out_valid[0]), 64'd1);
    checkOutput("bp held data", 64'(out_data[0]), 64'h0201_0000);
    checkOutput("bp unstable",  64'(unstable), 64'd0);
    checkOutput("bp no beats",  64'(beatCnt), 64'd0);
    out_ready[0] = 1'b1;
    runUntilDone(0, "bp");
    runCycles(0, 3);
    checkRow("bp", 32'h0201_0000, 32'h1211_1003, 32'h2221_2013);
    checkOutput("bp done count", 64'(doneCnt), 64'd1);

    $display("[TB] credit limit, single-entry FIFO");
    clearLog();
    out_ready[1] = 1'b0;
    applyStimulus(1, 8'd5);
    runCycles(1, 10);
    checkOutput("credit re count",  64'(reCnt), 64'd1);
    checkOutput("credit out_valid", 64'(out_valid[1]), 64'd1);
    checkOutput("credit data0",     64'(out_data[1]), 64'h0201_0000);
    out_ready[1] = 1'b1;
    sample(1);
    out_ready[1] = 1'b0;
    for (int i = 0; i < 10 && reCnt < 2; i++) sample(1);
    checkOutput("credit re after pop", 64'(reCnt), 64'd2);
    // re is registered: issue decided in the cycle after the pop edge, visible one edge later.
    checkOutput("credit reissue delay", 64'(reCyc[1] - hsCyc), 64'd2);
    out_ready[1] = 1'b1;
    runUntilDone(1, "credit");
    runCycles(1, 3);
    checkRow("credit", 32'h0201_0000, 32'h1211_1003, 32'h2221_2013);
    checkOutput("credit re total",   64'(reCnt), 64'd3);
    checkOutput("credit done count", 64'(doneCnt), 64'd1);

    $display("[TB] OFFSET=0 passthrough");
    clearLog();
    out_ready[2] = 1'b1;
    applyStimulus(2, 8'd7);
    runUntilDone(2, "off0");
    runCycles(2, 3);
    checkRow("off0", 32'h0302_0100, 32'h1312_1110, 32'h2322_2120);
    checkOutput("off0 raddrY", 64'(reY[0]), 64'd7);

    $display("[TB] reset mid-row");
    clearLog();
    out_ready[0] = 1'b1;
    applyStimulus(0, 8'd5);
    for (int i = 0; i < 10 && reCnt < 2; i++) sample(0);
    checkOutput("rst reached 2nd re", 64'(reCnt), 64'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("rst re",         64'(re[0]), 64'd0);
    checkOutput("rst busy",       64'(busy[0]), 64'd0);
    checkOutput("rst raddrY",     64'(raddrY[0]), 64'd0);
    checkOutput("rst raddrBlock", 64'(raddrBlock[0]), 64'd0);
    checkOutput("rst out_valid",  64'(out_valid[0]), 64'd0);
    checkOutput("rst out_data",   64'(out_data[0]), 64'd0);
    sample(0);
    rst_n = 1'b1;
    runCycles(0, 10);
    checkOutput("rst no stale beat", 64'(beatCnt), 64'd0);
    checkOutput("rst no done",       64'(doneCnt), 64'd0);
    clearLog();
    applyStimulus(0, 8'd5);
    runUntilDone(0, "restart");
    runCycles(0, 3);
    checkRow("restart", 32'h0201_0000, 32'h1211_1003, 32'h2221_2013);
    checkOutput("restart re count", 64'(reCnt), 64'd3);

    $display("[TB] start while busy");
    clearLog();
    applyStimulus(0, 8'd5);
    sample(0);
    applyStimulus(0, 8'd9);
    runUntilDone(0, "busy");
    runCycles(0, 10);
    checkOutput("busy re count",  64'(reCnt), 64'd3);
    checkOutput("busy raddrY0",   64'(reY[0]), 64'd5);
    checkOutput("busy raddrY1",   64'(reY[1]), 64'd5);
    checkOutput("busy raddrY2",   64'(reY[2]), 64'd5);
    checkOutput("busy raddrY end", 64'(raddrY[0]), 64'd5);
    checkOutput("busy done count", 64'(doneCnt), 64'd1);
    checkRow("busy", 32'h0201_0000, 32'h1211_1003, 32'h2221_2013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
